// File: rtl/adc_fifo_pkg.sv
// Shared defaults and helpers for the ADC sample FIFO.
//   DATA_W_DEF   : default sample width
//   DEPTH_DEF    : default number of entries (power of two)
//   AFULL_TH_DEF : default almost_full threshold
//   ptr_w()      : pointer width, log2(depth)
package adc_fifo_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int DEPTH_DEF    = 16;
  localparam int AFULL_TH_DEF = 12;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Sample storage: DEPTH x DATA_W register array.
//   clk     : clock, rising edge
//   i_we    : write enable, i_waddr/i_wdata : write address/data
//   i_re    : read enable,  i_raddr         : read address
//   o_rdata : registered read data, holds between reads
// Contents and the read register are intentionally not reset.
module fifo_mem
  import adc_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [ptr_w(DEPTH)-1:0]  i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic                     i_re,
  input  logic [ptr_w(DEPTH)-1:0]  i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/adc_sample_fifo.sv
// Synchronous FIFO buffering ADC samples from the SPI capture stage.
//   clk, reset_n      : clock (rising edge), async active-low reset
//   write_to_fifo     : write strobe, adc1_dout : sample data
//   rd_en             : read request, clr_flags : clear sticky flags
//   rd_data, rd_valid : read data, valid one cycle after accepted read
//   full, empty, almost_full, count : registered occupancy status
//   overflow, underflow : sticky dropped-write / ignored-read flags
module adc_sample_fifo
  import adc_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int AFULL_TH = AFULL_TH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    write_to_fifo,
  input  logic [DATA_W-1:0]       adc1_dout,
  input  logic                    rd_en,
  input  logic                    clr_flags,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [ptr_w(DEPTH):0]   count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_TH);

  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic              r_full, r_empty, r_afull;
  logic              r_rd_valid, r_rd_seen;
  logic              r_ovf, r_udf;
  logic              w_wr_acc, w_rd_acc;
  logic [DATA_W-1:0] w_mem_q;

  // A read frees a slot in the same edge, so a full FIFO still takes a write.
  assign w_rd_acc = rd_en & ~r_empty;
  assign w_wr_acc = write_to_fifo & (~r_full | w_rd_acc);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == DEPTH_C);
      r_empty    <= (w_count_nxt == '0);
      r_afull    <= (w_count_nxt >= AFULL_C);
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_seen <= 1'b1;
      // New events win over a simultaneous clear.
      r_ovf <= (write_to_fifo & ~w_wr_acc) | (r_ovf & ~clr_flags);
      r_udf <= (rd_en & r_empty)           | (r_udf & ~clr_flags);
    end
  end

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (adc1_dout),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_q)
  );

  // The memory read register has no reset; mask it to zero until the first
  // read after reset so stale pre-reset contents never appear on rd_data.
  assign rd_data     = r_rd_seen ? w_mem_q : '0;
  assign rd_valid    = r_rd_valid;
  assign full        = r_full;
  assign empty       = r_empty;
  assign almost_full = r_afull;
  assign count       = r_count;
  assign overflow    = r_ovf;
  assign underflow   = r_udf;

endmodule

// File: doc/adc_sample_fifo.md
ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 8, sample width; matches adc1_dout.
- DEPTH, 16, entries; power of two, at least 4.
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH.

REQ-002 The block SHALL have these ports:
- clk, input, 1, single system clock; all logic on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- write_to_fifo, input, 1, one-cycle write strobe from the SPI ADC stage.
- adc1_dout, input, DATA_W, sample data, qualified by write_to_fifo.
- rd_en, input, 1, read request from the consumer.
- clr_flags, input, 1, clears the sticky overflow and underflow flags.
- rd_data, output, DATA_W, read data.
- rd_valid, output, 1, rd_data valid this cycle.
- full, output, 1, count == DEPTH.
- empty, output, 1, count == 0.
- almost_full, output, 1, count >= AFULL_TH.
- count, output, log2(DEPTH)+1, current occupancy.
- overflow, output, 1, sticky; a write was dropped.
- underflow, output, 1, sticky; a read was ignored.

Function
REQ-003 A write SHALL be accepted when write_to_fifo=1 and (full=0 or an accepted read occurs in the same cycle); an accepted write stores adc1_dout at wr_ptr and increments wr_ptr.
REQ-004 A read SHALL be accepted when rd_en=1 and empty=0; an accepted read registers mem[rd_ptr] into rd_data, pulses rd_valid for exactly the next cycle, and increments rd_ptr.
REQ-005 Read latency SHALL be one clock from rd_en to rd_valid; rd_data SHALL hold its last value while rd_valid=0.
REQ-006 wr_ptr and rd_ptr SHALL be log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 with no gap.
REQ-007 count SHALL update in the same edge as the pointers: +1 for write only, -1 for read only, unchanged for both or neither.
REQ-008 full, empty and almost_full SHALL be registered outputs derived from the next-state count, so they are valid in the cycle after the causing edge.
REQ-009 A write when full with no accepted read SHALL be dropped, leave memory and pointers unchanged, and set overflow.
REQ-010 A read when empty SHALL be ignored, keep rd_valid=0, and set underflow; a write in the same cycle SHALL still be accepted.
REQ-011 Simultaneous read and write when full SHALL both succeed, leave count at DEPTH, and not set overflow.
REQ-012 Simultaneous read and write when empty SHALL accept the write only, set underflow, and leave count at 1 afterwards; there is no write-to-read bypass.
REQ-013 clr_flags=1 SHALL clear overflow and underflow on the next edge; if a new overflow or underflow event occurs in the same cycle, the set takes priority.
REQ-014 The block SHALL contain no state machine beyond the pointers, count and sticky flags, and SHALL add no combinational path from inputs to outputs.

Reset
REQ-015 On reset_n=0 the block SHALL asynchronously set wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0 and underflow=0.
REQ-016 Memory contents SHALL NOT be reset; a read after reset SHALL only ever return data written after reset.
REQ-017 Reset asserted mid-operation SHALL discard all stored samples; a write strobe on the first rising clock edge after reset release SHALL be accepted normally.

Structure
REQ-018 The package adc_fifo_pkg SHALL hold DATA_W_DEF=8, DEPTH_DEF=16, AFULL_TH_DEF=12 and a ptr_w function returning log2(DEPTH).
REQ-019 Storage SHALL be a sub-module fifo_mem: a DEPTH x DATA_W register array with one synchronous write port, one synchronous read port and no reset.
REQ-020 Pointer, count and flag logic SHALL reside in adc_sample_fifo.

Verification
REQ-021 Reset, then write 8'hAB, 8'hCD, then read twice -> rd_data=AB then CD, each with a one-cycle rd_valid; count goes 0,1,2,1,0; empty=1 at the end.
REQ-022 Write 16 samples 8'h00..8'h0F -> almost_full=1 once count=12, full=1 at count=16; a 17th write 8'hFF sets overflow=1 and count stays 16; a full drain returns 00..0F in order.
REQ-023 With the FIFO full, assert write 8'h55 and rd_en together -> rd_valid with 8'h00, count stays 16, overflow stays 0; 8'h55 is read out 16th.
REQ-024 With the FIFO empty, assert rd_en together with write 8'h77 -> rd_valid=0, underflow=1, count=1; the next read returns 8'h77; a clr_flags pulse then gives underflow=0.
REQ-025 Write 40 samples while reading continuously, so both pointers wrap twice -> output order matches input order and no flag is set.
REQ-026 Write 5 samples, pulse reset_n low for 3 ns between clock edges -> count=0 and empty=1 immediately; a following write 8'h3C then read returns 8'h3C.
